// File: rtl/cnt_timer_ctrl.sv
// Command-driven timer controller: sequences a WIDTH-bit up/down counter through a
// prescaler, with one-shot or periodic terminal-count handling.
module cnt_timer_ctrl #(
    parameter int WIDTH = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_dir,
    input  logic             cfg_mode,
    input  logic [PSC_W-1:0] cfg_psc,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_e;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;

    logic             accept;
    logic             step;
    logic [WIDTH-1:0] startVal;
    logic [WIDTH-1:0] endVal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            psc_cnt_q <= '0;
            period_q  <= '0;
            psc_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            period_q  <= period_d;
            psc_q     <= psc_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
        end
    end

    // An accepted command always takes priority over a prescaler step on the same edge.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        period_d  = period_q;
        psc_d     = psc_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;

        cmd_ready = (state_q != DONE);
        accept    = cmd_valid && cmd_ready;
        step      = (state_q == RUN) && (psc_cnt_q == psc_q);
        startVal  = dir_q ? '0 : period_q;
        endVal    = dir_q ? period_q : '0;

        if (accept) begin
            case (cmd_op)
                OP_START: begin
                    period_d  = cfg_period;
                    psc_d     = cfg_psc;
                    dir_d     = cfg_dir;
                    mode_d    = cfg_mode;
                    count_d   = cfg_dir ? '0 : cfg_period;
                    psc_cnt_d = '0;
                    state_d   = RUN;
                end
                OP_STOP: begin
                    psc_cnt_d = '0;
                    state_d   = IDLE;
                end
                OP_PAUSE: begin
                    if (state_q == RUN) begin
                        state_d = PAUSED;
                    end
                end
                OP_RESUME: begin
                    if (state_q == PAUSED) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            case (state_q)
                RUN: begin
                    if (step) begin
                        psc_cnt_d = '0;
                        if (count_q != endVal) begin
                            count_d = dir_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
                        end else begin
                            tick_d = 1'b1;
                            if (mode_q) begin
                                count_d = startVal;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        psc_cnt_d = psc_cnt_q + PSC_ONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Self-checking bench for cnt_timer_ctrl: per-scenario tasks, expected per-cycle
// outputs queued in a scoreboard and popped as the DUT produces them.
module tb_cnt_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cfg_period;
    logic        cfg_dir;
    logic        cfg_mode;
    logic [7:0]  cfg_psc;
    logic [15:0] count;
    logic        tick;
    logic        busy;
    logic [1:0]  state;

    typedef struct packed {
        logic [15:0] count;
        logic        tick;
        logic [1:0]  state;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10, S_DONE = 2'b11;
    localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_PAUSE = 2'b10, OP_RESUME = 2'b11;

    cnt_timer_ctrl #(.WIDTH(16), .PSC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cfg_period (cfg_period),
        .cfg_dir    (cfg_dir),
        .cfg_mode   (cfg_mode),
        .cfg_psc    (cfg_psc),
        .count      (count),
        .tick       (tick),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input logic [1:0] op, input logic [15:0] p, input logic d,
                          input logic m, input logic [7:0] s);
        cmd_op     = op;
        cfg_period = p;
        cfg_dir    = d;
        cfg_mode   = m;
        cfg_psc    = s;
        cmd_valid  = 1'b1;
    endtask

    // Drives one command for exactly one edge; returns #1 after that edge.
    task automatic issueCmd(input logic [1:0] op, input logic [15:0] p, input logic d,
                            input logic m, input logic [7:0] s);
        setCmd(op, p, d, m, s);
        nextCycle();
        cmd_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [15:0] c, input logic t, input logic [1:0] st);
        exp_t e;
        e.count = c;
        e.tick  = t;
        e.state = st;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cfg_period = '0;
        cfg_dir = 1'b0;
        cfg_mode = 1'b0;
        cfg_psc = '0;
        #3;
        checks++;
        if (count !== 16'h0 || tick !== 1'b0 || state !== S_IDLE || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state count=%h tick=%b state=%b busy=%b ready=%b want 0000 0 00 0 1",
                     count, tick, state, busy, cmd_ready);
        end
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checks++;
        if (state !== S_IDLE || count !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_idle state=%b count=%h want 00 0000", state, count);
        end
    endtask

    task automatic test_periodic_up();
        exp_t e;
        for (int k = 0; k < 12; k++)
            sbQ.push_back(mk(16'(k % 4), (k > 0) && (k % 4 == 0), S_RUN));
        issueCmd(OP_START, 16'd3, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 12; k++) begin
            e = sbQ.pop_front();
            checks++;
            if (count !== e.count || tick !== e.tick || state !== e.state) begin
                errors++;
                $display("[TB] FAIL periodic_up k=%0d got count=%h tick=%b state=%b want count=%h tick=%b state=%b",
                         k, count, tick, state, e.count, e.tick, e.state);
            end
            nextCycle();
        end
        issueCmd(OP_STOP, '0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (state !== S_IDLE || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_idle state=%b busy=%b want 00 0", state, busy);
        end
    endtask

    task automatic test_oneshot_down();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (k < 6)       sbQ.push_back(mk(16'(2 - k / 2), 1'b0, S_RUN));
            else if (k == 6) sbQ.push_back(mk(16'd0, 1'b1, S_DONE));
            else             sbQ.push_back(mk(16'd0, 1'b0, S_IDLE));
        end
        issueCmd(OP_START, 16'd2, 1'b0, 1'b0, 8'd1);
        for (int k = 0; k < 8; k++) begin
            e = sbQ.pop_front();
            checks++;
            if (count !== e.count || tick !== e.tick || state !== e.state) begin
                errors++;
                $display("[TB] FAIL oneshot_down k=%0d got count=%h tick=%b state=%b want count=%h tick=%b state=%b",
                         k, count, tick, state, e.count, e.tick, e.state);
            end
            checks++;
            if (cmd_ready !== (e.state != S_DONE) || busy !== (e.state != S_IDLE)) begin
                errors++;
                $display("[TB] FAIL oneshot_ready k=%0d got ready=%b busy=%b want ready=%b busy=%b",
                         k, cmd_ready, busy, e.state != S_DONE, e.state != S_IDLE);
            end
            nextCycle();
        end
    endtask

    // PAUSE is accepted on the edge after count shows 4 and RESUME four edges later,
    // so five steps' worth of edges are lost and the schedule shifts by five cycles.
    task automatic test_pause_resume();
        exp_t e;
        for (int k = 0; k < 19; k++) begin
            if (k <= 4)       sbQ.push_back(mk(16'(k), 1'b0, S_RUN));
            else if (k <= 8)  sbQ.push_back(mk(16'd4, 1'b0, S_PAUSED));
            else if (k == 9)  sbQ.push_back(mk(16'd4, 1'b0, S_RUN));
            else if (k <= 15) sbQ.push_back(mk(16'(k - 5), 1'b0, S_RUN));
            else              sbQ.push_back(mk(16'(k - 16), k == 16, S_RUN));
        end
        issueCmd(OP_START, 16'd10, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 19; k++) begin
            cmd_valid = 1'b0;
            e = sbQ.pop_front();
            checks++;
            if (count !== e.count || tick !== e.tick || state !== e.state) begin
                errors++;
                $display("[TB] FAIL pause_resume k=%0d got count=%h tick=%b state=%b want count=%h tick=%b state=%b",
                         k, count, tick, state, e.count, e.tick, e.state);
            end
            if (k == 4) setCmd(OP_PAUSE, '0, 1'b0, 1'b0, 8'd0);
            if (k == 8) setCmd(OP_RESUME, '0, 1'b0, 1'b0, 8'd0);
            nextCycle();
        end
        cmd_valid = 1'b0;
        issueCmd(OP_STOP, '0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 6; k++)
            sbQ.push_back(mk(16'(k % 2), k == 4, S_RUN));
        issueCmd(OP_START, 16'd1, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b0;
            e = sbQ.pop_front();
            checks++;
            if (count !== e.count || tick !== e.tick || state !== e.state) begin
                errors++;
                $display("[TB] FAIL restart_on_terminal k=%0d got count=%h tick=%b state=%b want count=%h tick=%b state=%b",
                         k, count, tick, state, e.count, e.tick, e.state);
            end
            if (k == 1) setCmd(OP_START, 16'd1, 1'b1, 1'b1, 8'd0);
            nextCycle();
        end
        cmd_valid = 1'b0;
        issueCmd(OP_STOP, '0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_async_reset();
        logic [1:0] ops [3];
        ops[0] = OP_STOP;
        ops[1] = OP_PAUSE;
        ops[2] = OP_RESUME;
        issueCmd(OP_START, 16'h1234, 1'b0, 1'b1, 8'd3);
        nextCycle();
        checks++;
        if (count !== 16'h1234 || state !== S_RUN) begin
            errors++;
            $display("[TB] FAIL pre_reset got count=%h state=%b want 1234 01", count, state);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 16'h0 || tick !== 1'b0 || state !== S_IDLE || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset count=%h tick=%b state=%b busy=%b ready=%b want 0000 0 00 0 1",
                     count, tick, state, busy, cmd_ready);
        end
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_ready op=%0d got %b want 1", i, cmd_ready);
            end
            issueCmd(ops[i], 16'h0055, 1'b1, 1'b1, 8'd0);
            nextCycle();
            checks++;
            if (state !== S_IDLE || count !== 16'h0 || busy !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_cmd op=%0d got state=%b count=%h busy=%b tick=%b want 00 0000 0 0",
                         i, state, count, busy, tick);
            end
        end
    endtask

    task automatic test_full_range();
        exp_t e;
        for (int k = 0; k < 65538; k++) begin
            if (k <= 65535) sbQ.push_back(mk(16'(k), 1'b0, S_RUN));
            else            sbQ.push_back(mk(16'(k - 65536), k == 65536, S_RUN));
        end
        issueCmd(OP_START, 16'hFFFF, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 65538; k++) begin
            e = sbQ.pop_front();
            checks++;
            if (count !== e.count || tick !== e.tick || state !== e.state) begin
                errors++;
                $display("[TB] FAIL full_range k=%0d got count=%h tick=%b state=%b want count=%h tick=%b state=%b",
                         k, count, tick, state, e.count, e.tick, e.state);
            end
            nextCycle();
        end
        issueCmd(OP_STOP, '0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_periodic_up();
        test_oneshot_down();
        test_pause_resume();
        test_back_to_back();
        test_async_reset();
        test_full_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
